// File: rtl/dmem_responder_if.sv
// Load/store request and response channel between the processor data port
// and dmem_responder; both directions use a valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word store of four byte lanes, one registered response
// per accepted request. Define DMEM_MISALIGN_CHK_EN to reject unaligned addresses.
module dmem_lane #(
  parameter int IDX_W  = 13,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LANE_W-1:0] wdata_i,
  output logic [LANE_W-1:0] rdata_o
);
  logic [LANE_W-1:0] mem_q [0:(1<<IDX_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];
endmodule

module dmem_responder #(
  parameter int          ADDR_W    = 15,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int          NUM_LANES = 4;
  localparam int          LANE_W    = 8;
  localparam int          IDX_W     = ADDR_W - 2;
  localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI    = WIN_LO + (33'd1 << ADDR_W);

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept, in_range, bad_align, err_d;
  logic [31:0] rdata_d;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_LANES-1:0]                 lane_we;
  logic [NUM_LANES-1:0][LANE_W-1:0]     wlane, rlane;

  assign bus.req_ready = (state_q == IDLE) || bus.rsp_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // 33-bit compare so a window touching the top of the address space cannot wrap
  assign in_range = ({1'b0, bus.req_addr} >= WIN_LO) && ({1'b0, bus.req_addr} < WIN_HI);

`ifdef DMEM_MISALIGN_CHK_EN
  assign bad_align = |bus.req_addr[1:0];
`else
  logic unused_lsb;
  assign bad_align  = 1'b0;
  assign unused_lsb = ^bus.req_addr[1:0];
`endif

  assign err_d = !in_range || bad_align;
  assign idx   = bus.req_addr[ADDR_W-1:2];
  assign wlane = bus.req_wdata;

  // Reset suppresses the write so a store presented alongside reset is dropped
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = accept && !reset && bus.req_we && !err_d && bus.req_be[g];

    dmem_lane #(.IDX_W(IDX_W), .LANE_W(LANE_W)) u_lane (
      .clk     (clk),
      .we_i    (lane_we[g]),
      .idx_i   (idx),
      .wdata_i (wlane[g]),
      .rdata_o (rlane[g])
    );
  end

  assign rdata_d = (bus.req_we || err_d) ? '0 : rlane;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      state_q     <= RESP;
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= rdata_d;
      rsp_err_q   <= err_d;
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-level reference memory, directed
// scenarios followed by randomized traffic with random response back-pressure.
module tb_dmem_responder;
  localparam int          ADDR_W = 15;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_b [int unsigned];
  int  n_chk = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b1;
  bit  rnd_bp = 1'b0;
  int  waited;
  logic [31:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: sparse byte memory; bytes never written are unknown and masked out
  function automatic exp_t model(input logic [31:0] addr, input bit we,
                                 input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    longint      a;
    bit          err;
    int unsigned w;
    a   = longint'(addr);
    err = !(a >= longint'(BASE) && a < longint'(BASE) + (longint'(1) << ADDR_W));
`ifdef DMEM_MISALIGN_CHK_EN
    if (addr[1:0] != 2'b00) err = 1'b1;
`endif
    e.err   = err;
    e.rdata = '0;
    e.mask  = '1;
    if (!err) begin
      w = (addr & 32'hFFFF_FFFC) - BASE;
      for (int n = 0; n < 4; n++) begin
        if (we) begin
          if (be[n]) ref_b[w + n] = wd[8*n +: 8];
        end else if (ref_b.exists(w + n)) begin
          e.rdata[8*n +: 8] = ref_b[w + n];
        end else begin
          e.mask[8*n +: 8] = 8'h00;
        end
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] addr, input bit we, input logic [31:0] wd,
                       input logic [3:0] be, output int wt);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(negedge clk);
    while (!bus.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    wt = t;
    if (!bus.req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready stuck 0 for addr %h", addr);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(addr, we, wd, be));
    #1;
    bus.req_valid = 1'b0;
    check("latency_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata %h err %b expected none", bus.rsp_rdata, bus.rsp_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
          check("rsp_rdata", bus.rsp_rdata & e.mask, e.rdata & e.mask);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = 1'b0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    check("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;

    issue(32'h0000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, waited);
    issue(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, waited);
    issue(32'h0000_0010, 1'b0, 32'h0, 4'h0, waited);
    check("load_full_word", bus.rsp_rdata, 32'hDEAD_BEEF);
    issue(32'h0000_0010, 1'b1, 32'h1122_3344, 4'b0101, waited);
    issue(32'h0000_0010, 1'b0, 32'h0, 4'h0, waited);
    check("load_byte_enable", bus.rsp_rdata, 32'hDE22_BE44);
    issue(32'h0000_0014, 1'b1, 32'hFFFF_FFFF, 4'b0000, waited);
    check("be_zero_err", {31'b0, bus.rsp_err}, 32'd0);

    issue(32'h0000_0020, 1'b1, 32'hA5A5_A5A5, 4'hF, waited);
    check("b2b_store_wait", waited, 0);
    issue(32'h0000_0020, 1'b0, 32'h0, 4'h0, waited);
    check("b2b_load_wait", waited, 0);
    check("write_first", bus.rsp_rdata, 32'hA5A5_A5A5);

    drain();
    bus.rsp_ready = 1'b0;
    issue(32'h0000_0010, 1'b0, 32'h0, 4'h0, waited);
    held = bus.rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      check("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, held);
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    issue(32'h0000_0020, 1'b0, 32'h0, 4'h0, waited);
    check("release_accept_same_cycle", waited, 0);

    issue(32'h0000_8000, 1'b1, 32'hFFFF_FFFF, 4'hF, waited);
    check("oor_err", {31'b0, bus.rsp_err}, 32'd1);
    check("oor_rdata", bus.rsp_rdata, 32'd0);
    issue(32'h0000_0000, 1'b0, 32'h0, 4'h0, waited);
    check("oor_no_write", bus.rsp_rdata, 32'h0BAD_F00D);

    issue(32'h0000_0012, 1'b1, 32'h5566_7788, 4'hF, waited);
    issue(32'h0000_0010, 1'b0, 32'h0, 4'h0, waited);
`ifdef DMEM_MISALIGN_CHK_EN
    check("misalign_no_write", bus.rsp_rdata, 32'hDE22_BE44);
`else
    check("misalign_writes_word", bus.rsp_rdata, 32'h5566_7788);
`endif

    drain();
    bus.rsp_ready = 1'b0;
    issue(32'h0000_0020, 1'b0, 32'h0, 4'h0, waited);
    mon_en        = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'hCAFE_F00D;
    bus.req_be    = 4'hF;
    bus.rsp_ready = 1'b1;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    check("reset_drops_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    sb.delete();
    mon_en = 1'b1;
    issue(32'h0000_0010, 1'b0, 32'h0, 4'h0, waited);
`ifdef DMEM_MISALIGN_CHK_EN
    check("reset_blocks_store", bus.rsp_rdata, 32'hDE22_BE44);
`else
    check("reset_blocks_store", bus.rsp_rdata, 32'h5566_7788);
`endif

    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h0000_8000 + 32'($urandom_range(0, 1000)) * 4;
      else if (r == 1) a = 32'hFFFF_FFFC;
      else             a = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
      if (r == 2) a[1:0] = 2'($urandom_range(0, 3));
      issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), waited);
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder that answers load/store requests from the processor's data port over a valid/ready request and response handshake. It holds a word-organised store built from four byte lanes, with byte-enable writes and out-of-range error signalling. It accepts one request per cycle, and each response is registered one cycle after acceptance. It sits between the processor's load/store path (address, write data, write enable) and the data RAM, replacing the fixed-timing memory hookup where wait states or back-pressure are needed.

## Interface
Parameters:
- ADDR_W, 15: byte-address bits decoded; capacity 2**ADDR_W bytes, 2**(ADDR_W-2) words.
- BASE_ADDR, 32'h0000_0000: byte base of the window; must be 2**ADDR_W aligned.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept this cycle.
- req_addr  in  32  byte address; word index = req_addr[ADDR_W-1:2].
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data; lane n = bits [8n+7:8n].
- req_be  in  4  byte enables for stores; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access rejected.

## Operation
- The clock is clk, and it is the only clock. Reset is synchronous and active-high, named reset.
- States:
  - IDLE: no response held.
  - RESP: response held on rsp_*.
- Handshake rules:
  - req_ready = (state==IDLE) || rsp_ready. This is combinational from rsp_ready only; req_ready never depends on req_valid.
  - Accept = req_valid && req_ready.
- On accept, address check:
  - In range: BASE_ADDR <= req_addr < BASE_ADDR + 2**ADDR_W.
  - Store in range: each lane n with req_be[n]=1 is written at the clock edge of acceptance. Lanes with req_be[n]=0 are unchanged.
  - Load in range: all four lanes of the word are read.
  - Out of range: no write occurs, rsp_err=1, rsp_rdata=0.
  - A store with req_be=4'b0000 writes nothing and has rsp_err=0.
- State transitions:
  - Accept moves to RESP (or stays in RESP) with new rsp_* values.
  - RESP && rsp_ready && !accept moves to IDLE, and rsp_valid goes to 0.
  - RESP && !rsp_ready holds rsp_valid, rsp_rdata and rsp_err stable, and req_ready=0.
- Ordering:
  - Responses return in request order, with at most one outstanding.
  - A load accepted the cycle after a store to the same word returns the post-store data (write-first).
- Memory contents:
  - Reset does not clear contents; contents are undefined until written.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE. req_ready=1 in the first cycle after reset.
- Latency: a request accepted at edge k has its response visible after edge k, so rsp_valid=1 in cycle k+1.
- Throughput: with rsp_ready held at 1, one request is accepted per cycle (back-to-back).
- Back-pressure: while rsp_valid && !rsp_ready, no request is accepted and the response holds indefinitely.
- Simultaneous retire and accept: in RESP with rsp_ready=1 and req_valid=1, the old response retires and the new response appears the next cycle, with no bubble.
- Reset mid-operation:
  - A held response is dropped, and rsp_valid=0 after the reset edge.
  - A store presented in the reset cycle is not performed; reset has priority over accept.
- Address wrap: word index uses only req_addr[ADDR_W-1:2] after the range check, so there is no aliasing inside the window.

## Configuration
- DMEM_MISALIGN_CHK_EN defined:
  - A request with req_addr[1:0] != 2'b00 is treated as an error: no write, rsp_err=1, rsp_rdata=0.
  - Range errors are still flagged.
- DMEM_MISALIGN_CHK_EN undefined:
  - req_addr[1:0] is ignored, and the access targets the containing word.

## Test plan
- Reset, then store 0xDEADBEEF at 0x0000_0010 with be=4'hF, then load 0x10: rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid exactly one cycle after each accept.
- Store 0x11223344 with be=4'b0101 over 0xDEADBEEF at 0x10, then load: 0xDE22BE44.
- Back-to-back with rsp_ready=1: store 0xA5A5A5A5 to 0x20, next cycle load 0x20: returns 0xA5A5A5A5 (write-first), no bubble.
- Hold rsp_ready=0 for 5 cycles after a load: req_ready=0 throughout, rsp_* stable. Raise rsp_ready with req_valid=1: new request accepted that same cycle.
- Store to 0x0000_8000 (ADDR_W=15): rsp_err=1, rsp_rdata=0, and a load of word 0 is unchanged. With DMEM_MISALIGN_CHK_EN, a store to 0x12 gives rsp_err=1 and no write. Without it, the store writes word 0x10.
- Assert reset while a response is held and a store is presented: rsp_valid=0 next cycle, and the store target is unchanged.
